// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between an instruction read port and a
// data read/write port. Each transaction occupies the memory for LATENCY cycles, then acks.
module memory_arbiter #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [ADDR_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;  // 1: data side owns the transaction
  logic              last_q, last_d;    // 1: data side was granted last
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] i_rdata_q, i_rdata_d;
  logic [ADDR_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_byte_q, mem_byte_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              grant_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    byte_d     = byte_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_data = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          // Under contention the side not served last wins.
          grant_data = d_req && (!i_req || !last_q);
          owner_d    = grant_data;
          last_d     = grant_data;
          addr_d     = grant_data ? d_addr : i_addr;
          we_d       = grant_data && d_we;
          byte_d     = grant_data && d_byte;
          wdata_d    = grant_data ? d_wdata : '0;
          cnt_d      = 4'(LATENCY - 1);
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          if (owner_q) d_rdata_d = mem_rdata;
          else         i_rdata_d = mem_rdata;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so decode them from the upcoming state.
    busy_d      = (state_d != StIdle);
    mem_read_d  = (state_d == StBusy) && !we_d;
    mem_write_d = (state_d == StBusy) && we_d && (cnt_d == 4'd0);
    mem_byte_d  = (state_d == StBusy) && byte_d;
    mem_addr_d  = (state_d == StBusy) ? addr_d : '0;
    mem_wdata_d = (state_d == StBusy) ? wdata_d : '0;
    i_ack_d     = (state_d == StResp) && !owner_d;
    d_ack_d     = (state_d == StResp) && owner_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      busy_q      <= busy_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_byte_q  <= mem_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_byte  = mem_byte_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
